// File: rtl/clk_div_gen_if.sv
// +---------------------------------------------------------------------------+
// | clk_div_gen_if : lock, divisor-programming and divided-clock signal bundle |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

interface clk_div_gen_if #(
  parameter int CHANNELS = 2,
  parameter int DIV_W    = 8
);
  logic                      pll_lock;
  logic [CHANNELS*DIV_W-1:0] div_val;
  logic                      div_load;
  logic                      div_busy;
  logic                      locked;
  logic                      rst_out_n;
  logic [CHANNELS-1:0]       clk_en;
  logic [CHANNELS-1:0]       clk_out;

  modport master (
    output pll_lock, div_val, div_load,
    input  div_busy, locked, rst_out_n, clk_en, clk_out
  );

  modport slave (
    input  pll_lock, div_val, div_load,
    output div_busy, locked, rst_out_n, clk_en, clk_out
  );
endinterface

`default_nettype wire

// File: rtl/clk_div_gen.sv
// +---------------------------------------------------------------------------+
// | clk_div_gen : PLL lock qualifier, downstream reset and N divided clocks   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module clk_div_gen #(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 8,
  parameter int DIV_INIT    = 4,
  parameter int LOCK_CYCLES = 16
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  clk_div_gen_if.slave  bus
);

  localparam int QUAL_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [0:0] {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_sync1;
  logic                      r_sync2;
  logic [QUAL_W-1:0]         r_qual;
  logic [CHANNELS*DIV_W-1:0] r_shadow;
  logic [CHANNELS-1:0]       w_pending;
  logic                      w_capture;
  logic                      w_run_nxt;
  logic                      w_keep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.pll_lock;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT;
      r_qual  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_qual  <= (r_state == ST_WAIT && r_sync2) ? r_qual + QUAL_W'(1) : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT: if (r_sync2 && r_qual == QUAL_W'(LOCK_CYCLES - 1)) w_state_nxt = ST_RUN;
      ST_RUN:  if (!r_sync2) w_state_nxt = ST_WAIT;
      default: w_state_nxt = ST_WAIT;
    endcase
  end

  assign bus.locked    = (r_state == ST_RUN);
  assign bus.rst_out_n = (r_state == ST_RUN);
  assign bus.div_busy  = |w_pending;
  assign w_capture     = bus.div_load && !(|w_pending);
  assign w_run_nxt     = (w_state_nxt == ST_RUN);
  // Counters advance only while RUN persists; entering or leaving RUN forces phase 0.
  assign w_keep        = (r_state == ST_RUN) && w_run_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (w_capture) begin
      r_shadow <= bus.div_val;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_pend;
    logic             r_out;
    logic             r_en;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W:0]   w_half;
    logic             w_adopt;

    always_comb begin
      w_adopt   = r_pend && (r_state == ST_WAIT || r_div == '0 ||
                             r_cnt == r_div - DIV_W'(1));
      w_div_nxt = w_adopt ? r_shadow[i*DIV_W +: DIV_W] : r_div;
      w_cnt_nxt = '0;
      if (w_keep && r_div != '0 && r_cnt != r_div - DIV_W'(1)) begin
        w_cnt_nxt = r_cnt + DIV_W'(1);
      end
      w_half = ({1'b0, w_div_nxt} + (DIV_W+1)'(1)) >> 1;
    end

    // Outputs are decoded from next-cycle count and divisor so they line up with r_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_div  <= DIV_W'(DIV_INIT);
        r_cnt  <= '0;
        r_pend <= 1'b0;
        r_out  <= 1'b0;
        r_en   <= 1'b0;
      end else begin
        r_div  <= w_div_nxt;
        r_cnt  <= w_cnt_nxt;
        r_out  <= w_run_nxt && (w_div_nxt != '0) && ({1'b0, w_cnt_nxt} < w_half);
        r_en   <= w_run_nxt && (w_div_nxt != '0) && (w_cnt_nxt == w_div_nxt - DIV_W'(1));
        if (w_capture) begin
          r_pend <= 1'b1;
        end else if (w_adopt) begin
          r_pend <= 1'b0;
        end
      end
    end

    assign w_pending[i]   = r_pend;
    assign bus.clk_out[i] = r_out;
    assign bus.clk_en[i]  = r_en;
  end

endmodule

`default_nettype wire
